// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a shared 4511-style BCD-to-7-segment decoder.
// Sequences digit drive with dead time, double-buffers the value, and applies LZB and lamp test.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    lzb_en,
  input  logic                    lamp_test,
  input  logic                    blank,
  output logic [3:0]              dec_D,
  output logic                    dec_LE,
  output logic                    dec_BL,
  output logic                    dec_LT,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    bcd_err
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         slot_end, frame_end;

  logic [NUM_DIGITS-1:0][3:0]   shadow_q, active_q;
  logic                         pending_q, lt_frame_q;
  logic [NUM_DIGITS-1:0]        lz_tail;
  logic [3:0]                   nib;

  logic [NUM_DIGITS-1:0]        digit_en_d;
  logic [3:0]                   dec_D_d;
  logic                         dec_BL_d, dec_LT_d, frame_done_d, bcd_err_d;

  // The latch-enable is tied low so the decoder stays transparent.
  assign dec_LE = 1'b0;

  // lz_tail[k] is set when nibbles k..NUM_DIGITS-1 of the displayed value are all zero.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lz_tail[k] = 1'b1;
      for (int j = k; j < NUM_DIGITS; j++) begin
        if (active_q[j] != 4'd0) lz_tail[k] = 1'b0;
      end
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    slot_end     = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
    frame_end    = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + 1'b1;
    state_d      = (cnt_d < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_SHOW;

    nib          = active_q[idx_q];
    digit_en_d   = '0;
    dec_D_d      = nib;
    dec_BL_d     = 1'b0;
    dec_LT_d     = 1'b1;
    frame_done_d = frame_end;
    bcd_err_d    = 1'b0;

    if (state_q == ST_SHOW) begin
      digit_en_d = NUM_DIGITS'(1) << idx_q;
      bcd_err_d  = (cnt_q == CNT_W'(BLANK_CYCLES)) && (nib > 4'd9);
      if (lt_frame_q) begin
        dec_LT_d = 1'b0;
        dec_BL_d = 1'b1;
      end else begin
        dec_BL_d = !(blank || (lzb_en && (idx_q != '0) && lz_tail[idx_q]));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= ST_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_en   <= '0;
      dec_D      <= 4'd0;
      dec_BL     <= 1'b0;
      dec_LT     <= 1'b1;
      frame_done <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      digit_en   <= digit_en_d;
      dec_D      <= dec_D_d;
      dec_BL     <= dec_BL_d;
      dec_LT     <= dec_LT_d;
      frame_done <= frame_done_d;
      bcd_err    <= bcd_err_d;
    end
  end

  // NOTE: the value buffers are plain registers, not RAM, and must come up cleared,
  // so they sit inside the reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      lt_frame_q <= 1'b0;
    end else begin
      if (load) shadow_q <= bcd_in;
      if (frame_end && pending_q) active_q <= shadow_q;
      // A load on the boundary cycle re-arms pending for the next boundary.
      if (load)           pending_q <= 1'b1;
      else if (frame_end) pending_q <= 1'b0;
      if ((cnt_q == '0) && (idx_q == '0)) lt_frame_q <= lamp_test;
    end
  end

endmodule
